// File: rtl/sync_fifo_prog_pkg.sv
// Shared types and constants for the programmable synchronous FIFO.
//   FIFO_WIDTH_DEF / FIFO_DEPTH_DEF : default geometry
//   fifo_resp_e                     : write-response classification (used by the scoreboard)
//   fifo_flags_t                    : bundle of the four status flags
//   cnt_width / ptr_width           : derived widths for level and pointer signals
package sync_fifo_prog_pkg;

   localparam int unsigned FIFO_WIDTH_DEF = 16;
   localparam int unsigned FIFO_DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      RESP_NONE,
      RESP_ACK,
      RESP_OVF
   } fifo_resp_e;

   typedef struct packed {
      logic full;
      logic empty;
      logic almostfull;
      logic almostempty;
   } fifo_flags_t;

   // Level must represent 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Pointers address 0..depth-1; keep at least one bit.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage : sync_fifo_prog_pkg

// File: rtl/sync_fifo_prog_if.sv
// Handshake/status bundle between the FIFO and its producer/consumer.
//   master : producer/consumer side (drives requests, data_in, flush, thresholds)
//   slave  : FIFO side (drives data_out, response pulses, status flags, level)
// Optional watermark signals (wmark_clr, peak_level) exist only when
// FIFO_WMARK_EN is defined.
interface sync_fifo_prog_if
   import sync_fifo_prog_pkg::*;
#(
   parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
);
   localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

   logic                  flush;
   logic [FIFO_WIDTH-1:0] data_in;
   logic                  wr_en;
   logic                  rd_en;
   logic [CNT_W-1:0]      af_thresh;
   logic [CNT_W-1:0]      ae_thresh;
   logic [FIFO_WIDTH-1:0] data_out;
   logic                  wr_ack;
   logic                  overflow;
   logic                  underflow;
   logic                  full;
   logic                  empty;
   logic                  almostfull;
   logic                  almostempty;
   logic [CNT_W-1:0]      level;
`ifdef FIFO_WMARK_EN
   logic                  wmark_clr;
   logic [CNT_W-1:0]      peak_level;
`endif

   modport master (
      output flush, data_in, wr_en, rd_en, af_thresh, ae_thresh,
`ifdef FIFO_WMARK_EN
      output wmark_clr,
      input  peak_level,
`endif
      input  data_out, wr_ack, overflow, underflow,
      input  full, empty, almostfull, almostempty, level
   );

   modport slave (
      input  flush, data_in, wr_en, rd_en, af_thresh, ae_thresh,
`ifdef FIFO_WMARK_EN
      input  wmark_clr,
      output peak_level,
`endif
      output data_out, wr_ack, overflow, underflow,
      output full, empty, almostfull, almostempty, level
   );

endinterface : sync_fifo_prog_if

// File: rtl/sync_fifo_prog_mem.sv
// Storage array for sync_fifo_prog (the fifo_mem block).
// Simple dual-port register file: synchronous write port, registered read
// port with enable. The read register clears on rst_n and otherwise holds
// when rd_en is low; the array itself is never cleared.
//   clk, rst_n        : clock, synchronous active-low reset (read register only)
//   wr_en/addr/data   : write port
//   rd_en/addr        : read request, loads rd_data at the same edge
//   rd_data           : registered read data
module sync_fifo_prog_mem #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ADDR_W     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [FIFO_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [FIFO_WIDTH-1:0] rd_data
);

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

   // Write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule : sync_fifo_prog_mem

// File: rtl/sync_fifo_prog.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, occupancy output and synchronous flush. Depth need not be a
// power of two; pointers wrap by explicit compare.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (priority over flush)
//   bus   : sync_fifo_prog_if.slave
//           in : flush, data_in, wr_en, rd_en, af_thresh, ae_thresh
//           out: data_out (registered), wr_ack/overflow/underflow (registered
//                pulses), full/empty/almostfull/almostempty/level (from
//                registered level and live thresholds)
// Optional: define FIFO_WMARK_EN to add wmark_clr input and peak_level output
// (maximum level since the last reset/flush/clear).
module sync_fifo_prog
   import sync_fifo_prog_pkg::*;
#(
   parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   sync_fifo_prog_if.slave bus
);

   localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);
   localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);

   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      level_q;
   logic [CNT_W-1:0]      level_d;
   logic                  wr_ack_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  run_c;
   logic                  wr_acc_c;
   logic                  rd_acc_c;
   logic [FIFO_WIDTH-1:0] rd_data;
   fifo_flags_t           flags_c;

   // Next pointer with wrap at FIFO_DEPTH-1.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Status flags from registered level and live thresholds.
   always_comb begin
      flags_c             = '0;
      flags_c.full        = (level_q == CNT_W'(FIFO_DEPTH));
      flags_c.empty       = (level_q == '0);
      // A threshold beyond depth can never be reached; keep the flag low.
      flags_c.almostfull  = (32'(bus.af_thresh) <= FIFO_DEPTH) && (level_q >= bus.af_thresh);
      flags_c.almostempty = (level_q <= bus.ae_thresh);
   end

   // Reset and flush both suppress any transfer in the current cycle.
   assign run_c = rst_n && !bus.flush;

   // Accept decisions and next level.
   always_comb begin
      wr_acc_c = 1'b0;
      rd_acc_c = 1'b0;
      level_d  = level_q;
      wr_acc_c = run_c && bus.wr_en && !flags_c.full;
      rd_acc_c = run_c && bus.rd_en && !flags_c.empty;
      if (wr_acc_c && !rd_acc_c) begin
         level_d = level_q + CNT_W'(1);
      end else if (rd_acc_c && !wr_acc_c) begin
         level_d = level_q - CNT_W'(1);
      end
   end

   // Pointers, level and response pulses.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc_c) begin
            wr_ptr_q <= ptr_next(wr_ptr_q);
         end
         if (rd_acc_c) begin
            rd_ptr_q <= ptr_next(rd_ptr_q);
         end
         level_q     <= level_d;
         wr_ack_q    <= wr_acc_c;
         overflow_q  <= bus.wr_en && !wr_acc_c;
         underflow_q <= bus.rd_en && !rd_acc_c;
      end
   end

   // Storage; read register clears only on rst_n so flush holds data_out.
   sync_fifo_prog_mem #(
      .FIFO_WIDTH (FIFO_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_W     (PTR_W)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_acc_c),
      .wr_addr (wr_ptr_q),
      .wr_data (bus.data_in),
      .rd_en   (rd_acc_c),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

`ifdef FIFO_WMARK_EN
   logic [CNT_W-1:0] peak_q;

   // Peak tracks the next level; a clear restarts it from that level.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
         peak_q <= '0;
      end else if (bus.wmark_clr || (level_d > peak_q)) begin
         peak_q <= level_d;
      end
   end

   assign bus.peak_level = peak_q;
`endif

   assign bus.data_out    = rd_data;
   assign bus.wr_ack      = wr_ack_q;
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;
   assign bus.full        = flags_c.full;
   assign bus.empty       = flags_c.empty;
   assign bus.almostfull  = flags_c.almostfull;
   assign bus.almostempty = flags_c.almostempty;
   assign bus.level       = level_q;

endmodule : sync_fifo_prog

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: a DEPTH=5 and a DEPTH=8 instance
// share one stimulus stream; both are compared each cycle with a queue-based
// reference model. Directed table and hand sequences add constant expectations.
// Honors FIFO_WMARK_EN for the watermark ports.
module tb_sync_fifo_prog;
   import sync_fifo_prog_pkg::*;

   localparam int unsigned W  = 16;
   localparam int unsigned D5 = 5;
   localparam int unsigned D8 = 8;
   localparam int unsigned C5 = cnt_width(D5);
   localparam int unsigned C8 = cnt_width(D8);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          flush;
   logic          wr_en;
   logic          rd_en;
   logic          wclr;
   logic [W-1:0]  data_in;
   logic [C5-1:0] af5, ae5;
   logic [C8-1:0] af8, ae8;

   sync_fifo_prog_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D5)) b5 ();
   sync_fifo_prog_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D8)) b8 ();

   assign b5.flush = flush;   assign b8.flush = flush;
   assign b5.wr_en = wr_en;   assign b8.wr_en = wr_en;
   assign b5.rd_en = rd_en;   assign b8.rd_en = rd_en;
   assign b5.data_in = data_in; assign b8.data_in = data_in;
   assign b5.af_thresh = af5; assign b5.ae_thresh = ae5;
   assign b8.af_thresh = af8; assign b8.ae_thresh = ae8;
`ifdef FIFO_WMARK_EN
   assign b5.wmark_clr = wclr; assign b8.wmark_clr = wclr;
`endif

   sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));
   sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, index 0 = DEPTH 5, index 1 = DEPTH 8.
   logic [W-1:0] mq0[$];
   logic [W-1:0] mq1[$];
   logic [W-1:0] m_dout [2];
   bit           m_ack  [2];
   bit           m_ovf  [2];
   bit           m_unf  [2];
   int           m_peak [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model one clock edge from the current inputs.
   task automatic model_step(input int k);
      logic [W-1:0] q[$];
      int d;
      bit wa, ra;
      d = (k == 0) ? int'(D5) : int'(D8);
      if (k == 0) q = mq0; else q = mq1;
      if (!rst_n || flush) begin
         q.delete();
         if (!rst_n) m_dout[k] = '0;
         m_ack[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_peak[k] = 0;
      end else begin
         wa = wr_en && (q.size() < d);
         ra = rd_en && (q.size() > 0);
         if (ra) m_dout[k] = q.pop_front();
         if (wa) q.push_back(data_in);
         m_ack[k] = wa;
         m_ovf[k] = wr_en && !wa;
         m_unf[k] = rd_en && !ra;
         if (wclr || (q.size() > m_peak[k])) m_peak[k] = q.size();
      end
      if (k == 0) mq0 = q; else mq1 = q;
   endtask

   function automatic int resp_of(input logic ack, input logic ovf);
      fifo_resp_e r;
      if (ack === 1'b1 && ovf === 1'b1) return 3;
      r = (ack === 1'b1) ? RESP_ACK : (ovf === 1'b1) ? RESP_OVF : RESP_NONE;
      return int'(r);
   endfunction

   task automatic check_dut(input string tag, input int k, input int depth, input int af,
                            input int ae, input int size, input logic [31:0] lvl,
                            input logic full, input logic empty, input logic afl,
                            input logic ael, input logic [W-1:0] dout, input logic ack,
                            input logic ovf, input logic unf);
      fifo_resp_e er;
      er = m_ack[k] ? RESP_ACK : (m_ovf[k] ? RESP_OVF : RESP_NONE);
      chk({tag, ".level"}, lvl, size);
      chk({tag, ".full"}, full, size == depth);
      chk({tag, ".empty"}, empty, size == 0);
      chk({tag, ".almostfull"}, afl, size >= af);
      chk({tag, ".almostempty"}, ael, size <= ae);
      chk({tag, ".data_out"}, dout, m_dout[k]);
      chk({tag, ".resp"}, resp_of(ack, ovf), int'(er));
      chk({tag, ".underflow"}, unf, m_unf[k]);
   endtask

   task automatic check_all();
      check_dut("d5", 0, D5, int'(af5), int'(ae5), mq0.size(), 32'(b5.level), b5.full, b5.empty,
                b5.almostfull, b5.almostempty, b5.data_out, b5.wr_ack, b5.overflow, b5.underflow);
      check_dut("d8", 1, D8, int'(af8), int'(ae8), mq1.size(), 32'(b8.level), b8.full, b8.empty,
                b8.almostfull, b8.almostempty, b8.data_out, b8.wr_ack, b8.overflow, b8.underflow);
`ifdef FIFO_WMARK_EN
      chk("d5.peak_level", 32'(b5.peak_level), m_peak[0]);
      chk("d8.peak_level", 32'(b8.peak_level), m_peak[1]);
`endif
   endtask

   // One clock: model, edge, sample 1 time unit later, compare.
   task automatic step();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      wr_en = 0; rd_en = 0; flush = 0; wclr = 0;
   endtask

   typedef struct {
      bit          wr;
      bit          rd;
      logic [15:0] din;
      bit          e_ack;
      bit          e_ovf;
      bit          e_unf;
      int          e_lvl;
      bit          e_full;
      bit          e_empty;
      logic [15:0] e_dout;
   } vec_t;

   function automatic vec_t mkv(input bit wr, input bit rd, input logic [15:0] din,
                                input bit ack, input bit ovf, input bit unf, input int lvl,
                                input bit full, input bit empty, input logic [15:0] dout);
      vec_t v;
      v.wr = wr; v.rd = rd; v.din = din; v.e_ack = ack; v.e_ovf = ovf; v.e_unf = unf;
      v.e_lvl = lvl; v.e_full = full; v.e_empty = empty; v.e_dout = dout;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[$];
      logic [W-1:0] held;

      // ---------------- reset ----------------
      rst_n = 0; idle(); data_in = '0;
      af5 = '0; ae5 = C5'(1); af8 = C8'(6); ae8 = C8'(2);
      step(); step();
      chk("rst.empty", b5.empty, 1'b1);
      chk("rst.full", b5.full, 1'b0);
      chk("rst.level", 32'(b5.level), 0);
      chk("rst.data_out", 32'(b5.data_out), 0);
      chk("rst.almostfull_af0", b5.almostfull, 1'b1);
      af5 = C5'(4);
      #1;
      chk("rst.almostfull_af4", b5.almostfull, 1'b0);
      rst_n = 1;

      // ---------------- DEPTH=5 table ----------------
      for (int i = 1; i <= 5; i++)
         vt.push_back(mkv(1, 0, 16'(i), 1, 0, 0, i, i == 5, 0, 16'h0000));
      vt.push_back(mkv(1, 0, 16'h0006, 0, 1, 0, 5, 1, 0, 16'h0000));
      for (int i = 1; i <= 5; i++)
         vt.push_back(mkv(0, 1, 16'h0000, 0, 0, 0, 5 - i, 0, i == 5, 16'(i)));
      vt.push_back(mkv(0, 1, 16'h0000, 0, 0, 1, 0, 0, 1, 16'h0005));
      vt.push_back(mkv(1, 1, 16'h00AA, 1, 0, 1, 1, 0, 0, 16'h0005));
      for (int i = 1; i <= 4; i++)
         vt.push_back(mkv(1, 0, 16'h00B0 + 16'(i), 1, 0, 0, 1 + i, i == 4, 0, 16'h0005));
      vt.push_back(mkv(1, 1, 16'h00CC, 0, 1, 0, 4, 0, 0, 16'h00AA));

      for (int i = 0; i < vt.size(); i++) begin
         wr_en = vt[i].wr; rd_en = vt[i].rd; data_in = vt[i].din;
         step();
         chk($sformatf("tbl%0d.wr_ack", i), b5.wr_ack, vt[i].e_ack);
         chk($sformatf("tbl%0d.overflow", i), b5.overflow, vt[i].e_ovf);
         chk($sformatf("tbl%0d.underflow", i), b5.underflow, vt[i].e_unf);
         chk($sformatf("tbl%0d.level", i), 32'(b5.level), vt[i].e_lvl);
         chk($sformatf("tbl%0d.full", i), b5.full, vt[i].e_full);
         chk($sformatf("tbl%0d.empty", i), b5.empty, vt[i].e_empty);
         chk($sformatf("tbl%0d.data_out", i), 32'(b5.data_out), 32'(vt[i].e_dout));
      end
      idle();

      // ---------------- thresholds, DEPTH=8 ----------------
      rst_n = 0; step(); rst_n = 1;
      chk("thr.ae@0", b8.almostempty, 1'b1);
      chk("thr.af@0", b8.almostfull, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         wr_en = 1; data_in = 16'(16'h0040 + i);
         step();
         chk($sformatf("thr.level@%0d", i), 32'(b8.level), i);
         chk($sformatf("thr.ae@%0d", i), b8.almostempty, i <= 2);
         chk($sformatf("thr.af@%0d", i), b8.almostfull, i >= 6);
      end
      idle();
      af8 = C8'(9);
      #1;
      chk("thr.af_over_depth", b8.almostfull, 1'b0);
      chk("thr.full", b8.full, 1'b1);
      af8 = C8'(6);

      // ---------------- threshold change + flush ----------------
      rst_n = 0; step(); rst_n = 1;
      for (int i = 1; i <= 5; i++) begin
         wr_en = 1; data_in = 16'(16'h0100 + i); step();
      end
      wr_en = 0; rd_en = 1; step(); rd_en = 0;
      chk("fl.level4", 32'(b8.level), 4);
      chk("fl.af6@4", b8.almostfull, 1'b0);
      af8 = C8'(3);
      #1;
      chk("fl.af3@4", b8.almostfull, 1'b1);
      held = b8.data_out;
      chk("fl.dout_before", 32'(held), 32'h0101);
      flush = 1; wr_en = 1; data_in = 16'hDEAD; step();
      flush = 0; wr_en = 0;
      chk("fl.level", 32'(b8.level), 0);
      chk("fl.empty", b8.empty, 1'b1);
      chk("fl.wr_ack", b8.wr_ack, 1'b0);
      chk("fl.data_out_held", 32'(b8.data_out), 32'h0101);
      for (int i = 1; i <= 4; i++) begin
         wr_en = 1; data_in = 16'(16'h0200 + i); step();
      end
      rst_n = 0; step(); rst_n = 1; wr_en = 0;
      chk("rs.level", 32'(b8.level), 0);
      chk("rs.wr_ack", b8.wr_ack, 1'b0);
      chk("rs.data_out", 32'(b8.data_out), 0);
      step();
      chk("rs.pulses_after", {b8.wr_ack, b8.overflow, b8.underflow}, 3'b000);
      af8 = C8'(6);

`ifdef FIFO_WMARK_EN
      // ---------------- watermark ----------------
      rst_n = 0; step(); rst_n = 1;
      for (int i = 1; i <= 7; i++) begin
         wr_en = 1; data_in = 16'(i); step();
      end
      wr_en = 0;
      for (int i = 1; i <= 5; i++) begin
         rd_en = 1; step();
      end
      rd_en = 0;
      chk("wm.level", 32'(b8.level), 2);
      chk("wm.peak7", 32'(b8.peak_level), 7);
      wclr = 1; step(); wclr = 0;
      chk("wm.peak_clr", 32'(b8.peak_level), 2);
`endif

      // ---------------- randomized run ----------------
      for (int p = 0; p < 15; p++) begin
         int wb, rb;
         wb = $urandom_range(10, 90);
         rb = $urandom_range(10, 90);
         for (int c = 0; c < 200; c++) begin
            if (c % 40 == 0) begin
               af5 = C5'($urandom); ae5 = C5'($urandom);
               af8 = C8'($urandom); ae8 = C8'($urandom);
            end
            wr_en   = ($urandom_range(0, 99) < wb);
            rd_en   = ($urandom_range(0, 99) < rb);
            data_in = W'($urandom);
            flush   = ($urandom_range(0, 63) == 0);
            rst_n   = ($urandom_range(0, 199) != 0);
            wclr    = ($urandom_range(0, 15) == 0);
            step();
         end
      end
      idle(); rst_n = 1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_sync_fifo_prog
